// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file: integer register file with two combinational read ports and one
// synchronous writeback port. x0 has no storage and always reads zero.
//
// Parameters:
//   WORDSIZE  width of each register and of every data port
//   REGCOUNT  number of architectural registers (must equal 2**ADDRW)
//   ADDRW     register address width
//
// Ports:
//   clk       clock, state updates on rising edge
//   rst_n     asynchronous active-low reset, clears x1..x(REGCOUNT-1)
//   rs1_addr  read port 1 index      rs1_data  read port 1 data (ALU in1)
//   rs2_addr  read port 2 index      rs2_data  read port 2 data (ALU in2)
//   we        writeback enable
//   rd_addr   writeback index        rd_data   writeback data
//
// Build option:
//   REGFILE_BYPASS_EN  when defined, a same-cycle write to a nonzero register
//                      is forwarded to any read port addressing it. When not
//                      defined, such reads see the pre-edge stored value.
// ---------------------------------------------------------------------------
module reg_file #(
  parameter int unsigned WORDSIZE = 32,
  parameter int unsigned REGCOUNT = 32,
  parameter int unsigned ADDRW    = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDRW-1:0]    rs1_addr,
  input  logic [ADDRW-1:0]    rs2_addr,
  output logic [WORDSIZE-1:0] rs1_data,
  output logic [WORDSIZE-1:0] rs2_data,
  input  logic                we,
  input  logic [ADDRW-1:0]    rd_addr,
  input  logic [WORDSIZE-1:0] rd_data
);

  if (REGCOUNT != (1 << ADDRW)) begin : g_bad_cfg
    $error("reg_file: REGCOUNT must equal 2**ADDRW");
  end

  // Storage starts at index 1; x0 is synthesised as a constant zero.
  logic [WORDSIZE-1:0] regs_q [1:REGCOUNT-1];

  logic wr_en;
  assign wr_en = we && (rd_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < int'(REGCOUNT); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      for (int i = 1; i < int'(REGCOUNT); i++) begin
        if (rd_addr == ADDRW'(i)) begin
          regs_q[i] <= rd_data;
        end
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Forwarding is suppressed during reset so reads stay at zero.
  logic fwd_en;
  assign fwd_en = wr_en && rst_n;
`endif

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_addr != '0) begin
      rs1_data = regs_q[rs1_addr];
    end
    if (rs2_addr != '0) begin
      rs2_data = regs_q[rs2_addr];
    end
`ifdef REGFILE_BYPASS_EN
    // wr_en already excludes rd_addr == 0, so x0 can never be forwarded.
    if (fwd_en && (rs1_addr == rd_addr)) begin
      rs1_data = rd_data;
    end
    if (fwd_en && (rs2_addr == rd_addr)) begin
      rs2_data = rd_data;
    end
`endif
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter WORDSIZE, default 32: width of every register and data port.
REQ-002 SHALL have parameter REGCOUNT, default 32: number of architectural registers, x0..x(REGCOUNT-1).
REQ-003 SHALL have parameter ADDRW, default 5: width of every register address; REGCOUNT SHALL equal 2**ADDRW.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port rs1_addr, input, ADDRW: read port 1 register index.
REQ-007 SHALL have port rs2_addr, input, ADDRW: read port 2 register index.
REQ-008 SHALL have port rs1_data, output, WORDSIZE: read port 1 data; drives ALU in1.
REQ-009 SHALL have port rs2_data, output, WORDSIZE: read port 2 data; drives ALU in2 path.
REQ-010 SHALL have port we, input, 1: write enable for the writeback port.
REQ-011 SHALL have port rd_addr, input, ADDRW: writeback register index.
REQ-012 SHALL have port rd_data, input, WORDSIZE: writeback data, normally ALU result or load data.

Function
REQ-013 SHALL implement REGCOUNT-1 storage registers x1..x(REGCOUNT-1); x0 SHALL have no storage.
REQ-014 SHALL read combinationally: rs1_data/rs2_data follow rs1_addr/rs2_addr and stored contents in the same cycle, zero latency.
REQ-015 SHALL return 0 on any read port whose address is 0, regardless of we/rd_addr/rd_data.
REQ-016 SHALL, on rising clk with we=1 and rd_addr!=0, store rd_data into x[rd_addr]; visible on reads from the next cycle.
REQ-017 SHALL ignore writes with we=0 or rd_addr=0; no register changes.
REQ-018 SHALL permit both read ports to address the same register; both return identical data.
REQ-019 SHALL leave registers other than x[rd_addr] unchanged on every edge.
REQ-020 SHALL, on same-cycle read and write of the same nonzero register, return per REQ-027/REQ-028.
REQ-021 SHALL hold all contents indefinitely while we=0.
REQ-022 SHALL treat X/unknown rd_data identically to any value; no data-dependent suppression.

Reset
REQ-023 SHALL clear x1..x(REGCOUNT-1) to 0 immediately when rst_n falls, independent of clk.
REQ-024 SHALL hold all registers at 0 and ignore writes while rst_n=0; rs1_data/rs2_data SHALL read 0 for every address during reset.
REQ-025 SHALL discard a write whose clk edge coincides with rst_n=0 (reset dominates).
REQ-026 SHALL accept writes starting with the first rising clk after rst_n rises.

Configuration
REQ-027 SHALL, with macro REGFILE_BYPASS_EN defined, forward rd_data to any read port whose address equals rd_addr while we=1 and rd_addr!=0 and rst_n=1 (write-before-read, same cycle).
REQ-028 SHALL, with REGFILE_BYPASS_EN undefined, return the pre-edge stored value on such a same-cycle read; no forwarding logic instantiated.

Verification
REQ-029 SHALL cover: reset, then read x1..x31 on both ports -> all 0; assert rst_n=0 mid-run after writing x5=0xDEADBEEF -> rs1_data for x5 reads 0 immediately, before next clk.
REQ-030 SHALL cover: we=1, rd_addr=0, rd_data=0xFFFFFFFF, edge; read x0 on both ports -> 0.
REQ-031 SHALL cover: write x7=0x12345678, next cycle rs1_addr=rs2_addr=7 -> both 0x12345678; write with we=0, rd_data=0xAAAA5555 -> x7 unchanged.
REQ-032 SHALL cover: x3=0x11, same cycle we=1, rd_addr=3, rd_data=0x22, rs1_addr=3 -> 0x22 with REGFILE_BYPASS_EN, 0x11 without; next cycle 0x22 both builds.
REQ-033 SHALL cover: write x31=0x80000000 and x1=0x1 on consecutive edges -> x31 reads 0x80000000, x1 reads 0x1, x2..x30 remain 0.
REQ-034 SHALL cover: rst_n low coinciding with clk edge and we=1, rd_addr=9, rd_data=0x55 -> after release x9 reads 0.
